// File: rtl/shift_out_reg_pkg.sv
// rtl/shift_out_reg_pkg.sv - shared FSM state type and default width for the PISO serializer
package shift_out_reg_pkg;

  // Serializer FSM: waiting for a load, or streaming bits out
  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_e;

  localparam int SHIFT_OUT_DEFAULT_WIDTH = 32;

endpackage

// File: rtl/shift_out_reg.sv
// rtl/shift_out_reg.sv - parallel-in serial-out shift register, MSB first (optional o_BUSY via SHIFT_OUT_REG_BUSY_EN)
import shift_out_reg_pkg::*;

module shift_out_reg #(
  parameter int DATA_WIDTH = SHIFT_OUT_DEFAULT_WIDTH
) (
  input  logic                  i_CLK,
  input  logic                  i_RST_N,
  input  logic                  i_START,
  input  logic [DATA_WIDTH-1:0] i_D,
`ifdef SHIFT_OUT_REG_BUSY_EN
  output logic                  o_BUSY,
`endif
  output logic                  o_Q
);

  localparam int              CW       = $clog2(DATA_WIDTH) + 1;
  localparam logic [CW-1:0]   LAST_CNT = CW'(DATA_WIDTH - 1);

  state_e                  state_q, state_d;
  logic [DATA_WIDTH-1:0]   sreg_q,  sreg_d;
  logic [CW-1:0]           cnt_q,   cnt_d;

  // Next-state: a start always (re)loads; otherwise shift until the last bit-time, then clear
  always_comb begin
    state_d = state_q;
    sreg_d  = sreg_q;
    cnt_d   = cnt_q;
    if (i_START) begin
      sreg_d  = i_D;
      cnt_d   = '0;
      state_d = SHIFT;
    end else if (state_q == SHIFT) begin
      cnt_d = cnt_q + CW'(1);
      if (cnt_q == LAST_CNT) begin
        // Last bit has been on the line for one cycle; return the line to idle 0
        sreg_d  = '0;
        state_d = IDLE;
      end else begin
        sreg_d = {sreg_q[DATA_WIDTH-2:0], 1'b0};
      end
    end
  end

  // State registers; reset abandons any transfer in progress
  always_ff @(posedge i_CLK or negedge i_RST_N) begin
    if (!i_RST_N) begin
      state_q <= IDLE;
      sreg_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      sreg_q  <= sreg_d;
      cnt_q   <= cnt_d;
    end
  end

  // Serial line comes straight from the top shift-register flop
  assign o_Q = sreg_q[DATA_WIDTH-1];

`ifdef SHIFT_OUT_REG_BUSY_EN
  logic busy_q, busy_d;

  always_comb begin
    busy_d = (state_d == SHIFT);
  end

  // Busy flag registered alongside the FSM so it drops on the same edge o_Q returns to 0
  always_ff @(posedge i_CLK or negedge i_RST_N) begin
    if (!i_RST_N) begin
      busy_q <= 1'b0;
    end else begin
      busy_q <= busy_d;
    end
  end

  assign o_BUSY = busy_q;
`endif

endmodule

// File: tb/tb_shift_out_reg.sv
// tb/tb_shift_out_reg.sv - scoreboard bench for shift_out_reg (checks o_BUSY when SHIFT_OUT_REG_BUSY_EN is defined)
module tb_shift_out_reg;

  localparam int W = 32;

  typedef struct packed {
    logic busy;
    logic q;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic [W-1:0]  d;
  logic          q;
`ifdef SHIFT_OUT_REG_BUSY_EN
  logic          busy;
`endif

  int   n_checks = 0;
  int   n_fail   = 0;
  exp_t exp_q[$];

  always #5 clk = ~clk;

  shift_out_reg #(.DATA_WIDTH(W)) dut (
    .i_CLK   (clk),
    .i_RST_N (rst_n),
    .i_START (start),
    .i_D     (d),
`ifdef SHIFT_OUT_REG_BUSY_EN
    .o_BUSY  (busy),
`endif
    .o_Q     (q)
  );

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Queue expected line values for bits [from, to) of w, optionally followed by the idle 0
  task automatic push_word(input logic [W-1:0] w, input int from, input int to, input bit tail);
    for (int k = from; k < to; k++) exp_q.push_back(exp_t'{busy: 1'b1, q: w[W-1-k]});
    if (tail) exp_q.push_back(exp_t'{busy: 1'b0, q: 1'b0});
  endtask

  task automatic pop_check(input string tag);
    exp_t e;
    n_checks++;
    assert (exp_q.size() != 0) else begin
      n_fail++;
      $error("FAIL %s_sb observed=empty expected=entry", tag);
    end
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      check({tag, "_q"}, W'(q), W'(e.q));
`ifdef SHIFT_OUT_REG_BUSY_EN
      check({tag, "_busy"}, W'(busy), W'(e.busy));
`endif
    end
  endtask

  // Sample n cycles starting now (first sample needs no edge); collect the first W bits
  task automatic run_samples(input string tag, input int n, input bit scramble,
                             output logic [W-1:0] recon);
    recon = '0;
    for (int i = 0; i < n; i++) begin
      if (i > 0) tick();
      if (scramble) d = $urandom;
      if (i < W) recon = {recon[W-2:0], q};
      pop_check(tag);
    end
  endtask

  task automatic send(input string tag, input logic [W-1:0] w, input bit scramble);
    logic [W-1:0] recon;
    d     = w;
    start = 1'b1;
    push_word(w, 0, W, 1'b1);
    tick();
    start = 1'b0;
    run_samples(tag, W + 1, scramble, recon);
    check({tag, "_word"}, recon, w);
  endtask

  initial begin
    logic [W-1:0] recon;
    rst_n = 1'b0;
    start = 1'b0;
    d     = '0;

    // Reset held for two cycles
    tick();
    tick();
    exp_q.push_back(exp_t'{busy: 1'b0, q: 1'b0});
    pop_check("reset");
    #2 rst_n = 1'b1;
    tick();
    exp_q.push_back(exp_t'{busy: 1'b0, q: 1'b0});
    pop_check("idle_after_reset");

    // Basic patterns
    send("p12345678", 32'h12345678, 1'b0);
    send("pF0F0F0F0", 32'hF0F0F0F0, 1'b0);
    send("p00000000", 32'h00000000, 1'b0);
    send("pFFFFFFFF", 32'hFFFFFFFF, 1'b0);

    // i_D wiggles during the transfer must not reach the line
    send("isolate", 32'h12345678, 1'b1);

    // Restart after 10 bits of the old word
    d     = 32'hAAAAAAAA;
    start = 1'b1;
    push_word(32'hAAAAAAAA, 0, 10, 1'b0);
    tick();
    start = 1'b0;
    run_samples("restart_old", 10, 1'b0, recon);
    d     = 32'h80000001;
    start = 1'b1;
    push_word(32'h80000001, 0, W, 1'b1);
    tick();
    start = 1'b0;
    run_samples("restart_new", W + 1, 1'b0, recon);
    check("restart_word", recon, 32'h80000001);

    // Start held high for three edges: line shows each new MSB, then streams the last word
    d     = 32'h7FFFFFFF;
    start = 1'b1;
    push_word(32'h7FFFFFFF, 0, 1, 1'b0);
    tick();
    pop_check("hold1");
    d = 32'h80000000;
    push_word(32'h80000000, 0, 1, 1'b0);
    tick();
    pop_check("hold2");
    d = 32'h3C3C3C3C;
    push_word(32'h3C3C3C3C, 0, W, 1'b1);
    tick();
    start = 1'b0;
    run_samples("hold3", W + 1, 1'b0, recon);
    check("hold3_word", recon, 32'h3C3C3C3C);

    // Asynchronous reset after 5 bits, applied between clock edges
    d     = 32'hFFFFFFFF;
    start = 1'b1;
    push_word(32'hFFFFFFFF, 0, 5, 1'b0);
    tick();
    start = 1'b0;
    run_samples("pre_reset", 5, 1'b0, recon);
    #2 rst_n = 1'b0;
    #1;
    exp_q.push_back(exp_t'{busy: 1'b0, q: 1'b0});
    pop_check("async_reset");
    tick();
    #2 rst_n = 1'b1;
    for (int i = 0; i < 5; i++) exp_q.push_back(exp_t'{busy: 1'b0, q: 1'b0});
    tick();
    run_samples("post_reset_idle", 5, 1'b0, recon);

    // Normal operation resumes after reset
    send("post_reset", 32'hC0FFEE01, 1'b0);

    n_checks++;
    assert (exp_q.size() == 0) else begin
      n_fail++;
      $error("FAIL sb_drain observed=%0d expected=0", exp_q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
